// File: rtl/activation_output_writer_if.sv
// Row-stream input and BRAM write-port bundle for the activation output writer.
// The master side drives the job controls and row stream; the slave side is the writer.
interface activation_output_writer_if #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4,
  parameter int AWIDTH       = 10,
  parameter int CWIDTH       = 8
);
  logic                           enable_writer;
  logic [AWIDTH-1:0]              start_addr;
  logic [AWIDTH-1:0]              addr_stride;
  logic [CWIDTH-1:0]              num_rows;
  logic                           in_data_available;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data;
  logic [MASK_WIDTH-1:0]          validity_mask;
  logic                           bram_en;
  logic [MAT_MUL_SIZE-1:0]        bram_we;
  logic [AWIDTH-1:0]              bram_addr;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata;
  logic                           done_writer;

  modport master (
    output enable_writer, start_addr, addr_stride, num_rows,
    output in_data_available, in_data, validity_mask,
    input  bram_en, bram_we, bram_addr, bram_wdata, done_writer
  );

  modport slave (
    input  enable_writer, start_addr, addr_stride, num_rows,
    input  in_data_available, in_data, validity_mask,
    output bram_en, bram_we, bram_addr, bram_wdata, done_writer
  );
endinterface

// File: rtl/activation_output_writer.sv
// Drains activation rows into the output BRAM at a strided address sequence,
// zeroing invalid lanes and raising a sticky done once the programmed row count is written.
module activation_output_writer #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4,
  parameter int AWIDTH       = 10,
  parameter int CWIDTH       = 8
) (
  input logic                    clk,
  input logic                    reset,
  activation_output_writer_if.slave bus
);
  localparam int RW = MAT_MUL_SIZE * DWIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [AWIDTH-1:0]       addr_ptr;
  logic [AWIDTH-1:0]       stride_q;
  logic [CWIDTH-1:0]       rows_q;
  logic [CWIDTH-1:0]       row_cnt;
  logic [CWIDTH-1:0]       row_cnt_nxt;
  logic                    wr_en;
  logic [MAT_MUL_SIZE-1:0] wr_we;
  logic [AWIDTH-1:0]       wr_addr;
  logic [RW-1:0]           wr_data;
  logic                    done;

  function automatic logic [RW-1:0] mask_lanes(input logic [RW-1:0]         data,
                                               input logic [MASK_WIDTH-1:0] mask);
    logic [RW-1:0] res;
    res = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      if (mask[i]) res[i*DWIDTH +: DWIDTH] = data[i*DWIDTH +: DWIDTH];
    end
    return res;
  endfunction

  assign row_cnt_nxt = row_cnt + CWIDTH'(1);

  // Job descriptor is plain data: latched on job start, never needs a reset value.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.enable_writer) begin
      stride_q <= bus.addr_stride;
      rows_q   <= bus.num_rows;
    end
    if (state == IDLE && bus.enable_writer) begin
      addr_ptr <= bus.start_addr;
    end else if (state == RUN && bus.enable_writer && bus.in_data_available) begin
      addr_ptr <= addr_ptr + stride_q;
    end
  end

  // Accept stage -> registered BRAM write port (one cycle latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      wr_en   <= 1'b0;
      wr_we   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      wr_we <= '0;
      case (state)
        IDLE: begin
          wr_addr <= '0;
          wr_data <= '0;
          done    <= 1'b0;
          if (bus.enable_writer) begin
            row_cnt <= '0;
            if (bus.num_rows == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!bus.enable_writer) begin
            state   <= IDLE;
            wr_addr <= '0;
            wr_data <= '0;
          end else if (bus.in_data_available) begin
            wr_en   <= 1'b1;
            wr_we   <= bus.validity_mask;
            wr_addr <= addr_ptr;
            wr_data <= mask_lanes(bus.in_data, bus.validity_mask);
            row_cnt <= row_cnt_nxt;
            if (row_cnt_nxt == rows_q) state <= DONE;
          end
        end
        DONE: begin
          if (bus.enable_writer) begin
            done <= 1'b1;
          end else begin
            state   <= IDLE;
            done    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bram_en     = wr_en;
  assign bus.bram_we     = wr_we;
  assign bus.bram_addr   = wr_addr;
  assign bus.bram_wdata  = wr_data;
  assign bus.done_writer = done;
endmodule

// File: tb/tb_activation_output_writer.sv
// Bench for activation_output_writer: directed vector table, hand-written corner
// sequences, and randomized jobs checked against an address/count reference model.
module tb_activation_output_writer;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  activation_output_writer_if #(.DWIDTH(DW), .MAT_MUL_SIZE(N), .MASK_WIDTH(N),
                                .AWIDTH(AW), .CWIDTH(CW)) bus();

  activation_output_writer #(.DWIDTH(DW), .MAT_MUL_SIZE(N), .MASK_WIDTH(N),
                             .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          gap;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } row_vec_t;

  typedef struct {
    logic [9:0] start;
    logic [9:0] stride;
    logic [7:0] n;
    int         first;
  } job_vec_t;

  row_vec_t rows[9];
  job_vec_t jobs[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic en, input logic [3:0] we, input logic done);
    chk({name, ".en"},   64'(bus.bram_en),     64'(en));
    chk({name, ".we"},   64'(bus.bram_we),     64'(we));
    chk({name, ".done"}, 64'(bus.done_writer), 64'(done));
  endtask

  task automatic chk_wr(input string name, input logic [9:0] addr, input logic [31:0] wdata);
    chk({name, ".addr"},  64'(bus.bram_addr),  64'(addr));
    chk({name, ".wdata"}, 64'(bus.bram_wdata), 64'(wdata));
  endtask

  task automatic drive(input logic en, input logic avail, input logic [31:0] data, input logic [3:0] mask);
    bus.enable_writer     = en;
    bus.in_data_available = avail;
    bus.in_data           = data;
    bus.validity_mask     = mask;
  endtask

  task automatic start_job(input logic [9:0] start, input logic [9:0] stride, input logic [7:0] n);
    bus.start_addr  = start;
    bus.addr_stride = stride;
    bus.num_rows    = n;
    drive(1'b1, 1'b0, 32'h0, 4'h0);
    tick();
  endtask

  function automatic logic [31:0] exp_mask(input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) r[i*8 +: 8] = data[i*8 +: 8];
    end
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  s, st, exp_a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        avail, exp_en;
    int          n, acc, acc_before, extra, guard, last;

    rows[0] = '{0, 32'h04030201, 4'hF, 10'h010, 4'hF, 32'h04030201};
    rows[1] = '{0, 32'h04030202, 4'hF, 10'h011, 4'hF, 32'h04030202};
    rows[2] = '{0, 32'h04030203, 4'hF, 10'h012, 4'hF, 32'h04030203};
    rows[3] = '{0, 32'h04030204, 4'hF, 10'h013, 4'hF, 32'h04030204};
    rows[4] = '{0, 32'hAABBCCDD, 4'b0101, 10'h010, 4'b0101, 32'h00BB00DD};
    rows[5] = '{3, 32'h11223344, 4'b1010, 10'h014, 4'b1010, 32'h11003300};
    rows[6] = '{0, 32'hDEADBEEF, 4'hF, 10'h3FE, 4'hF, 32'hDEADBEEF};
    rows[7] = '{1, 32'h12345678, 4'b0011, 10'h3FF, 4'b0011, 32'h00005678};
    rows[8] = '{0, 32'hCAFEF00D, 4'b1000, 10'h000, 4'b1000, 32'hCA000000};
    jobs[0] = '{10'h010, 10'd1, 8'd4, 0};
    jobs[1] = '{10'h010, 10'd4, 8'd2, 4};
    jobs[2] = '{10'h3FE, 10'd1, 8'd3, 6};

    // Reset state
    reset = 1'b1;
    bus.start_addr = '0; bus.addr_stride = '0; bus.num_rows = '0;
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 4'hF);
    tick();
    tick();
    chk_ctl("reset", 1'b0, 4'h0, 1'b0);
    chk_wr("reset", 10'h0, 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    tick();

    // Table-driven jobs
    for (int j = 0; j < 3; j++) begin
      start_job(jobs[j].start, jobs[j].stride, jobs[j].n);
      chk_ctl("tbl.start", 1'b0, 4'h0, 1'b0);
      last = jobs[j].first + int'(jobs[j].n) - 1;
      for (int r = jobs[j].first; r <= last; r++) begin
        for (int g = 0; g < rows[r].gap; g++) begin
          drive(1'b1, 1'b0, 32'h55555555, 4'hF);
          tick();
          chk_ctl("tbl.bubble", 1'b0, 4'h0, 1'b0);
        end
        drive(1'b1, 1'b1, rows[r].data, rows[r].mask);
        tick();
        chk_ctl("tbl.row", 1'b1, rows[r].exp_we, 1'b0);
        chk_wr("tbl.row", rows[r].exp_addr, rows[r].exp_wdata);
      end
      drive(1'b1, 1'b1, 32'h99999999, 4'hF);
      tick();
      chk_ctl("tbl.done", 1'b0, 4'h0, 1'b1);
      tick();
      chk_ctl("tbl.extra", 1'b0, 4'h0, 1'b1);
      chk_wr("tbl.hold", rows[last].exp_addr, rows[last].exp_wdata);
      drive(1'b0, 1'b0, 32'h0, 4'h0);
      tick();
      chk_ctl("tbl.release", 1'b0, 4'h0, 1'b0);
    end

    // Zero rows, release, then a fresh job from a new start address
    start_job(10'h100, 10'd1, 8'd0);
    chk_ctl("zero.done", 1'b0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h12121212, 4'hF);
    tick();
    chk_ctl("zero.hold", 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    chk_ctl("zero.release", 1'b0, 4'h0, 1'b0);
    start_job(10'h200, 10'd2, 8'd1);
    chk_ctl("zero.restart", 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h0A0B0C0D, 4'hF);
    tick();
    chk_ctl("zero.row", 1'b1, 4'hF, 1'b0);
    chk_wr("zero.row", 10'h200, 32'h0A0B0C0D);
    drive(1'b1, 1'b0, 32'h0, 4'h0);
    tick();
    chk_ctl("zero.done2", 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    tick();

    // Abort with a row present in the same cycle
    start_job(10'h040, 10'd1, 8'd8);
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b1, 32'h70000000 + r, 4'hF);
      tick();
      chk_ctl("abort.row", 1'b1, 4'hF, 1'b0);
      chk_wr("abort.row", 10'(10'h040 + r), 32'h70000000 + r);
    end
    drive(1'b0, 1'b1, 32'h7FFFFFFF, 4'hF);
    tick();
    chk_ctl("abort.cut", 1'b0, 4'h0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_ctl("abort.idle", 1'b0, 4'h0, 1'b0);
    end
    chk_wr("abort.idle", 10'h0, 32'h0);

    // Reset mid-job
    start_job(10'h080, 10'd1, 8'd4);
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 1'b1, 32'h30000000 + r, 4'hF);
      tick();
      chk_ctl("rst.row", 1'b1, 4'hF, 1'b0);
    end
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h3FFFFFFF, 4'hF);
    tick();
    chk_ctl("rst.mid", 1'b0, 4'h0, 1'b0);
    chk_wr("rst.mid", 10'h0, 32'h0);
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_ctl("rst.after", 1'b0, 4'h0, 1'b0);
    end
    start_job(10'h0C0, 10'd1, 8'd1);
    drive(1'b1, 1'b1, 32'h01020304, 4'hF);
    tick();
    chk_ctl("rst.newjob", 1'b1, 4'hF, 1'b0);
    chk_wr("rst.newjob", 10'h0C0, 32'h01020304);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    tick();

    // Randomized jobs against the reference model
    for (int j = 0; j < 25; j++) begin
      s  = 10'($urandom);
      st = 10'($urandom);
      n  = $urandom_range(1, 10);
      acc = 0; extra = 0; guard = 0;
      start_job(s, st, 8'(n));
      chk_ctl("rnd.start", 1'b0, 4'h0, 1'b0);
      while ((acc < n || extra < 3) && guard < 400) begin
        guard++;
        avail = ($urandom_range(0, 9) < 6);
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        drive(1'b1, avail, d, m);
        acc_before = acc;
        exp_en = avail && (acc < n);
        tick();
        chk_ctl("rnd.cycle", exp_en, exp_en ? m : 4'h0, acc_before == n);
        if (exp_en) begin
          exp_a = 10'(int'(s) + acc * int'(st));
          chk_wr("rnd.write", exp_a, exp_mask(d, m));
          acc++;
        end
        if (acc_before == n) extra++;
      end
      if (guard >= 400) begin
        tests++;
        fails++;
        $display("FAIL rnd.budget: job %0d got %0d rows, expected %0d", j, acc, n);
      end
      drive(1'b0, 1'b0, 32'h0, 4'h0);
      tick();
      chk_ctl("rnd.release", 1'b0, 4'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/activation_output_writer.md
Name: activation_output_writer

Overview:
- Drain side of the activation stage: consumes the row stream activation emits (data + data-available strobe + validity mask) and writes each row into the output BRAM at a strided address sequence.
- Counts accepted rows, masks invalid lanes, and raises a sticky done flag for the top-level control FSM once the programmed number of rows has been committed.
- Sits between the activation output and the output BRAM write port.

Parameters:
- DWIDTH, 8, bits per lane element
- MAT_MUL_SIZE, 4, lanes per row
- MASK_WIDTH, 4, validity-mask bits, one per lane (equals MAT_MUL_SIZE)
- AWIDTH, 10, BRAM address width
- CWIDTH, 8, row-count width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable_writer  in  1  level enable; a high level in IDLE starts a job, and low aborts or releases the block
- start_addr  in  AWIDTH  first BRAM row address, sampled on job start
- addr_stride  in  AWIDTH  address increment per written row, sampled on job start
- num_rows  in  CWIDTH  rows to write, sampled on job start
- in_data_available  in  1  row-valid strobe from activation
- in_data  in  MAT_MUL_SIZE*DWIDTH  row data; lane i is bits [i*DWIDTH +: DWIDTH]
- validity_mask  in  MASK_WIDTH  bit i=1 means lane i is valid for the current row
- bram_en  out  1  BRAM write strobe
- bram_we  out  MAT_MUL_SIZE  per-lane write enables
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  MAT_MUL_SIZE*DWIDTH  write data
- done_writer  out  1  job complete (sticky)

Behaviour:
- Reset: clk and reset as stated above. All outputs are 0 on the edge where reset is sampled high; state goes to IDLE and counters clear. A reset mid-job discards the job, and no further writes are issued.
- States: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Taken when enable_writer=1.
  - Latches start_addr into addr_ptr, addr_stride into stride_q, num_rows into rows_q; row_cnt=0.
  - If num_rows=0, goes IDLE -> DONE instead, with done_writer=1 one cycle after enable is seen and no BRAM writes.
- RUN, each cycle with in_data_available=1 (row accepted):
  - Next edge (1-cycle registered latency): bram_en=1, bram_addr=addr_ptr, bram_we=validity_mask.
  - bram_wdata lane i = in_data lane i if validity_mask[i], else 0.
  - addr_ptr += stride_q, modulo 2^AWIDTH (wraps silently). row_cnt += 1.
- RUN, cycles with in_data_available=0: bram_en=0, bram_we=0; addr_ptr and row_cnt hold. Bubbles are legal and unlimited.
- bram_addr and bram_wdata hold their last values when bram_en=0. bram_we is 0 whenever bram_en=0.
- Last row: when the accepted row makes row_cnt equal rows_q, the write issues normally and the state moves to DONE on the same edge. done_writer=1 on the cycle after the last write's bram_en pulse.
- DONE:
  - done_writer stays 1 while enable_writer=1.
  - in_data_available is ignored, with no writes and no counting.
  - enable_writer=0 -> IDLE next edge, done_writer=0.
- Abort: enable_writer=0 while in RUN -> IDLE next edge; done_writer stays 0.
  - A row presented in that same cycle is NOT written.
  - Rows written earlier remain in BRAM.
- IDLE: in_data_available is ignored; outputs are 0.
- Simultaneous events: reset has priority over everything. Abort has priority over row accept.
- A new job requires passing through IDLE, so enable_writer must drop for at least one cycle after done.
- Maximum throughput is one row per cycle; the block never back-pressures the activation stage.

Test Plan:
- Basic job: start_addr=0x010, stride=1, num_rows=4, four back-to-back rows 0x04030201..0x04030204 with mask=4'hF -> writes at 0x010..0x013 with we=4'hF, data unchanged; done_writer=1 the cycle after the 4th bram_en; no 5th write when a 5th strobe arrives.
- Masking and bubbles: num_rows=2, stride=4; row A=0xAABBCCDD with mask=4'b0101, then 3 idle cycles, then row B=0x11223344 with mask=4'b1010 -> writes (0x010, we=0101, data 0x00BB00DD) then (0x014, we=1010, data 0x11003300).
- Wrap-around: start_addr=0x3FE, stride=1, num_rows=3 -> addresses 0x3FE, 0x3FF, 0x000.
- Zero rows and release: num_rows=0 -> done_writer=1 one cycle after enable with no bram_en; drop enable -> done_writer=0 next cycle; a re-enable starts a fresh job from the newly sampled start_addr.
- Abort: num_rows=8; drop enable after 3 rows while a 4th strobe is present -> exactly 3 writes, done never asserts, state IDLE.
- Reset mid-job: assert reset after 2 of 4 rows -> all outputs 0 next cycle; subsequent strobes produce no writes until a new enable.
